cam_row_stream_ctrl: RTL

//  Stream-side controller for the CAM cell array's row (and optionally column) ports.

---
 rtl/cam_row_stream_ctrl.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/cam_row_stream_ctrl.sv
// cam_row_stream_ctrl
//   Stream-side controller for the CAM cell array row/column ports.
//   LOAD writes a valid/ready word stream into the array; UNLOAD sweeps the
//   read address, absorbs the array's 2-cycle read latency through a tag
//   shift register and returns the words through a skid FIFO.
//   Optional feature macro: COL_MODE_EN (column-oriented load/unload).
module cam_row_stream_ctrl #(
  parameter int          DATA_WIDTH     = 4,
  parameter int          DATA_DEPTH     = 4,
  parameter int          ADDR_WIDTH_CAM = 8,
  parameter logic [2:0]  RowxRow        = 3'd1,
  parameter logic [2:0]  ColxCol        = 3'd2,
  parameter int          SKID_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_op,
  input  logic                      cmd_col,
  output logic                      done,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DATA_WIDTH-1:0]     s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_WIDTH-1:0]     m_data,
  output logic [2:0]                arr_mode,
  output logic                      arr_rstIn,
  output logic [ADDR_WIDTH_CAM-1:0] arr_addr_in_row,
  output logic [ADDR_WIDTH_CAM-1:0] arr_addr_in_col,
  output logic [ADDR_WIDTH_CAM-1:0] arr_addr_out_row,
  output logic [ADDR_WIDTH_CAM-1:0] arr_addr_out_col,
  output logic [DATA_WIDTH-1:0]     arr_ip_row,
  output logic [DATA_DEPTH-1:0]     arr_ip_col,
  input  logic [DATA_WIDTH-1:0]     arr_q_row,
  input  logic [DATA_DEPTH-1:0]     arr_q_col
);

  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CNT_W = $clog2(SKID_DEPTH + 1);

  // Parked read addresses lie outside the array so its output is gated.
  localparam logic [ADDR_WIDTH_CAM-1:0] ROW_PARK = ADDR_WIDTH_CAM'(DATA_DEPTH + 3);
  localparam logic [ADDR_WIDTH_CAM-1:0] COL_PARK = ADDR_WIDTH_CAM'(DATA_WIDTH + 3);
  localparam logic [ADDR_WIDTH_CAM-1:0] ROW_LAST = ADDR_WIDTH_CAM'(DATA_DEPTH - 1);
  localparam logic [ADDR_WIDTH_CAM-1:0] COL_LAST = ADDR_WIDTH_CAM'(DATA_WIDTH - 1);
  localparam logic [PTR_W-1:0]          PTR_LAST = PTR_W'(SKID_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_UNLOAD = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                      state_q, state_d;
  logic [ADDR_WIDTH_CAM-1:0]   idx_q, idx_d;
  logic                        tag_p1_q, tag_p1_d;
  logic                        tag_p2_q, tag_p2_d;
  logic [DATA_WIDTH-1:0]       fifo_mem_q [SKID_DEPTH];
  logic [DATA_WIDTH-1:0]       fifo_mem_d [SKID_DEPTH];
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  logic                        col_sel;
  logic                        issue;
  logic                        push;
  logic                        pop;
  logic [DATA_WIDTH-1:0]       cap_data;
  logic [ADDR_WIDTH_CAM-1:0]   last_idx;
  logic [2:0]                  cmd_mode;
  int                          credit;

`ifdef COL_MODE_EN
  logic col_q, col_d;

  // Orientation latched when a command is accepted.
  always_ff @(posedge clk) begin
    if (!rst) col_q <= 1'b0;
    else      col_q <= col_d;
  end

  // Capture cmd_col only on command acceptance.
  always_comb begin
    col_d = col_q;
    if (state_q == S_IDLE && cmd_valid) col_d = cmd_col;
  end

  assign col_sel = col_q;
`else
  logic unused_col_inputs;
  assign unused_col_inputs = ^{cmd_col, arr_q_col};
  assign col_sel = 1'b0;
`endif

  assign last_idx = col_sel ? COL_LAST : ROW_LAST;
  assign cmd_mode = col_sel ? ColxCol : RowxRow;
  assign cap_data = col_sel ? DATA_WIDTH'(arr_q_col) : arr_q_row;

  assign m_valid  = (cnt_q != '0);
  assign m_data   = m_valid ? fifo_mem_q[rd_ptr_q] : '0;
  assign push     = tag_p2_q;
  assign pop      = m_valid & m_ready;

  // FSM next state, index counter and combinational array/stream controls.
  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    cmd_ready        = 1'b0;
    s_ready          = 1'b0;
    done             = 1'b0;
    arr_mode         = 3'd0;
    arr_rstIn        = 1'b1;
    arr_addr_in_row  = '0;
    arr_addr_in_col  = '0;
    arr_addr_out_row = ROW_PARK;
    arr_addr_out_col = COL_PARK;
    arr_ip_row       = '0;
    arr_ip_col       = '0;
    issue            = 1'b0;
    // Reads already in flight hold a FIFO slot even though not yet pushed.
    credit = SKID_DEPTH - int'(cnt_q) - int'(tag_p1_q) - int'(tag_p2_q);

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          idx_d   = '0;
          state_d = cmd_op ? S_UNLOAD : S_LOAD;
        end
      end
      S_LOAD: begin
        s_ready   = 1'b1;
        arr_mode  = cmd_mode;
        arr_rstIn = ~s_valid;
        if (col_sel) begin
          arr_addr_in_col = idx_q;
          arr_ip_col      = DATA_DEPTH'(s_data);
        end else begin
          arr_addr_in_row = idx_q;
          arr_ip_row      = s_data;
        end
        if (s_valid) begin
          if (idx_q == last_idx) state_d = S_DONE;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      S_UNLOAD: begin
        arr_mode = cmd_mode;
        if (credit > 0) begin
          issue = 1'b1;
          if (col_sel) arr_addr_out_col = idx_q;
          else         arr_addr_out_row = idx_q;
          if (idx_q == last_idx) state_d = S_DRAIN;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      S_DRAIN: begin
        arr_mode = cmd_mode;
        if (cnt_q == '0 && !tag_p1_q && !tag_p2_q) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read-latency tag pipeline: a tag reaches stage 2 when array data is valid.
  always_comb begin
    tag_p1_d = issue;
    tag_p2_d = tag_p1_q;
  end

  // Skid FIFO pointer/occupancy update and storage write.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = cap_data;
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control registers; reset aborts any command and flushes the FIFO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      tag_p1_q <= 1'b0;
      tag_p2_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tag_p1_q <= tag_p1_d;
      tag_p2_q <= tag_p2_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // FIFO storage; contents are only visible through cnt_q, so no reset.
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

endmodule
